// File: rtl/muldiv_scheduler_if.sv
// ----------------------------------------------------------------------------
// muldiv_scheduler_if
// Bundles every non-clock, non-reset signal of muldiv_scheduler: the MUL and
// DIV reservation-station issue ports, the shared multiply/divide unit port,
// the CDB writeback port, the mispredict flush and the busy status.
//   slave  : the scheduler's view (receives requests, drives acks/unit/CDB)
//   master : the surrounding core's view (RS, unit, CDB arbiter, flush)
// ----------------------------------------------------------------------------
interface muldiv_scheduler_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
);
    logic             flush;
    logic             multReq;
    logic [TAG_W-1:0] multTag;
    logic [WIDTH-1:0] multA;
    logic [WIDTH-1:0] multB;
    logic             multAck;
    logic             divReq;
    logic [TAG_W-1:0] divTag;
    logic [WIDTH-1:0] divA;
    logic [WIDTH-1:0] divB;
    logic             divAck;
    logic             unitStart;
    logic             unitDiv;
    logic [WIDTH-1:0] unitA;
    logic [WIDTH-1:0] unitB;
    logic [WIDTH-1:0] unitResult;
    logic             cdbReq;
    logic             cdbGrant;
    logic [TAG_W-1:0] cdbTag;
    logic [WIDTH-1:0] cdbValue;
    logic             busy;

    modport slave (
        input  flush,
        input  multReq, multTag, multA, multB,
        output multAck,
        input  divReq, divTag, divA, divB,
        output divAck,
        output unitStart, unitDiv, unitA, unitB,
        input  unitResult,
        output cdbReq, cdbTag, cdbValue,
        input  cdbGrant,
        output busy
    );

    modport master (
        output flush,
        output multReq, multTag, multA, multB,
        input  multAck,
        output divReq, divTag, divA, divB,
        input  divAck,
        input  unitStart, unitDiv, unitA, unitB,
        output unitResult,
        input  cdbReq, cdbTag, cdbValue,
        output cdbGrant,
        input  busy
    );
endinterface

// File: rtl/muldiv_scheduler.sv
// ----------------------------------------------------------------------------
// muldiv_scheduler
// Shares one fixed-latency multiply/divide unit between the MUL and DIV
// reservation stations. Requests are arbitrated round-robin, the chosen op is
// latched and launched, its latency is counted down, and the captured result
// is held on the CDB until granted.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears state and every output
//   bus    : muldiv_scheduler_if.slave (issue, unit, CDB, flush, busy)
// Acks are combinational; all other outputs come straight from registers.
// ----------------------------------------------------------------------------
module muldiv_scheduler #(
    parameter int WIDTH   = 64,
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_scheduler_if.slave   bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               ptr_div_last_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               unit_start_r;
    logic               unit_div_r;
    logic [WIDTH-1:0]   unit_a_r;
    logic [WIDTH-1:0]   unit_b_r;
    logic [TAG_W-1:0]   tag_r;
    logic [WIDTH-1:0]   cdb_value_r;

    logic               window_s;
    logic               mult_ack_s;
    logic               div_ack_s;
    logic               accept_s;
    logic               div_zero_s;
    logic               cnt_zero_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic [TAG_W-1:0]   sel_tag_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = div_zero_s ? ST_WB : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WB: begin
                if (bus.cdbGrant) begin
                    if (accept_s) begin
                        state_nxt_s = div_zero_s ? ST_WB : ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (bus.flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Output logic: accept window, round-robin acks, status decode.
    always_comb begin
        window_s   = 1'b0;
        mult_ack_s = 1'b0;
        div_ack_s  = 1'b0;
        if (!reset && !bus.flush &&
            ((state_r == ST_IDLE) || ((state_r == ST_WB) && bus.cdbGrant))) begin
            window_s = 1'b1;
        end else begin
            window_s = 1'b0;
        end
        if (window_s) begin
            if (bus.multReq && bus.divReq) begin
                // Tie: serve whoever was not served last.
                mult_ack_s = ptr_div_last_r;
                div_ack_s  = !ptr_div_last_r;
            end else begin
                mult_ack_s = bus.multReq;
                div_ack_s  = bus.divReq;
            end
        end else begin
            mult_ack_s = 1'b0;
            div_ack_s  = 1'b0;
        end
        bus.multAck = mult_ack_s;
        bus.divAck  = div_ack_s;
        bus.cdbReq  = (state_r == ST_WB);
        bus.busy    = (state_r != ST_IDLE);
    end

    // Operand/tag selection for the accepted requester.
    always_comb begin
        accept_s   = mult_ack_s | div_ack_s;
        cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
        if (div_ack_s) begin
            sel_a_s    = bus.divA;
            sel_b_s    = bus.divB;
            sel_tag_s  = bus.divTag;
            div_zero_s = (bus.divB == {WIDTH{1'b0}});
        end else begin
            sel_a_s    = bus.multA;
            sel_b_s    = bus.multB;
            sel_tag_s  = bus.multTag;
            div_zero_s = 1'b0;
        end
    end

    // Datapath: operand latch, latency counter, result capture, RR pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_div_last_r <= 1'b1;
            cnt_r          <= {CNT_W{1'b0}};
            unit_start_r   <= 1'b0;
            unit_div_r     <= 1'b0;
            unit_a_r       <= {WIDTH{1'b0}};
            unit_b_r       <= {WIDTH{1'b0}};
            tag_r          <= {TAG_W{1'b0}};
            cdb_value_r    <= {WIDTH{1'b0}};
        end else begin
            // A divide by zero never reaches the unit.
            unit_start_r <= accept_s && !div_zero_s;
            if (accept_s) begin
                ptr_div_last_r <= div_ack_s;
                unit_div_r     <= div_ack_s;
                unit_a_r       <= sel_a_s;
                unit_b_r       <= sel_b_s;
                tag_r          <= sel_tag_s;
                cnt_r          <= div_ack_s ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                if (div_zero_s) begin
                    cdb_value_r <= {WIDTH{1'b0}};
                end else begin
                    cdb_value_r <= cdb_value_r;
                end
            end else if ((state_r == ST_RUN) && !bus.flush) begin
                if (cnt_zero_s) begin
                    cdb_value_r <= bus.unitResult;
                end else begin
                    cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.unitStart = unit_start_r;
    assign bus.unitDiv   = unit_div_r;
    assign bus.unitA     = unit_a_r;
    assign bus.unitB     = unit_b_r;
    assign bus.cdbTag    = tag_r;
    assign bus.cdbValue  = cdb_value_r;

endmodule
